// File: rtl/hamming7_pkg.sv
// Shared Hamming(7,4) definitions: bit positions, receive-assembler state and
// the data-nibble extract used by the encoder, corrector and rx assembler.
package hamming7_pkg;

  // Codeword bit positions, numbered [7:1] as on the wire.
  localparam int D7_POS = 7;
  localparam int D6_POS = 6;
  localparam int D5_POS = 5;
  localparam int D3_POS = 3;
  localparam int C4_POS = 4;
  localparam int C2_POS = 2;
  localparam int C1_POS = 1;

  typedef enum logic {
    S_HI = 1'b0,
    S_LO = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_byte_t;

  function automatic logic [3:0] ham7_nibble(input logic [7:1] dc);
    return {dc[D7_POS], dc[D6_POS], dc[D5_POS], dc[D3_POS]};
  endfunction

endpackage

// File: rtl/hamming7_byte_fifo.sv
// Small byte+error FIFO; DEPTH must be a power of two (>= 2). Head is read
// combinationally from registered storage so it is stable while stalled.
module hamming7_byte_fifo
  import hamming7_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_en,
  input  rx_byte_t wr_data,
  input  logic     rd_en,
  output rx_byte_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_ptr, rd_ptr;
  rx_byte_t [DEPTH-1:0]   mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hamming7_rx_assembler.sv
// Pairs corrected Hamming(7,4) nibbles into bytes (high first) behind a FIFO.
// Define HAM7_RX_ERRCNT_EN to build the saturating corrected-codeword counter.
module hamming7_rx_assembler
  import hamming7_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                SCLR,
  input  logic                CW_VALID,
  output logic                CW_READY,
  input  logic [7:1]          DC,
  input  logic                NOERROR,
  output logic                BYTE_VALID,
  input  logic                BYTE_READY,
  output logic [7:0]          BYTE,
  output logic                BYTE_ERR,
  output logic [ERRCNT_W-1:0] ERRCNT
);

  rx_state_e  state;
  logic [3:0] hi_q;
  logic       hierr_q;
  logic [3:0] nib;
  logic       accept, wr_en, rd_en, full, empty;
  rx_byte_t   wr_data, head;
  logic       unused_chk;

  assign nib        = ham7_nibble(DC);
  assign unused_chk = ^{DC[C4_POS], DC[C2_POS], DC[C1_POS]};

  // Ready never looks at BYTE_READY; a full FIFO only stalls the low nibble.
  assign CW_READY = ~SCLR & ((state == S_HI) | ~full);
  assign accept   = CW_VALID & CW_READY;
  assign wr_en    = accept & (state == S_LO);
  assign rd_en    = BYTE_VALID & BYTE_READY;
  assign wr_data  = '{err: hierr_q | ~NOERROR, data: {hi_q, nib}};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_HI;
      hi_q    <= '0;
      hierr_q <= 1'b0;
    end else if (SCLR) begin
      state   <= S_HI;
      hi_q    <= '0;
      hierr_q <= 1'b0;
    end else if (accept) begin
      case (state)
        S_HI: begin
          hi_q    <= nib;
          hierr_q <= ~NOERROR;
          state   <= S_LO;
        end
        default: state <= S_HI;
      endcase
    end
  end

`ifdef HAM7_RX_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                    errcnt_q <= '0;
    else if (SCLR)                                 errcnt_q <= '0;
    else if (accept && !NOERROR && errcnt_q != '1) errcnt_q <= errcnt_q + 1'b1;
  end

  assign ERRCNT = errcnt_q;
`else
  assign ERRCNT = '0;
`endif

  hamming7_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign BYTE_VALID = ~empty;
  assign BYTE       = head.data;
  assign BYTE_ERR   = head.err;

endmodule
